// File: rtl/mtm_alu_frame_rx.sv
// -----------------------------------------------------------------------------
// mtm_alu_frame_rx
//
// Serial packet receiver for the MTM ALU. It deframes 11-bit frames from a
// single-bit line and assembles them into an ALU request: 2*NB DATA bytes
// (operand A then operand B, MSB byte first) followed by one CTL byte
// {1'b0, OP[2:0], CRC[3:0]}. A good packet presents A/B/OP with a one-cycle
// valid_o pulse. A bad packet raises a one-cycle err_o pulse with exactly one
// error flag set.
//
// Frame on sin (one bit per clk): start 0, type (0 DATA / 1 CTL),
// 8 payload bits MSB first, stop 1.
//
// Parameters:
//   OPERAND_W   operand width, a multiple of 8 in 8..64 (NB = OPERAND_W/8)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sin          serial input, idles high
//   a_o, b_o     operands of the last good packet
//   op_o         operation code of the last good packet
//   valid_o      one-cycle pulse, good packet
//   err_o        one-cycle pulse, rejected packet
//   err_flags_o  {ERR_DATA, ERR_CRC, ERR_OP}, meaningful while err_o is high
//
// Build option:
//   MTM_ALU_FRAME_RX_CRC_CHECK_EN  when defined, a bit-serial CRC-4
//   (x^4+x+1, init 0) over {A, B, 1'b1, OP} is built and checked against
//   CTL[3:0]. When undefined, no CRC logic exists and ERR_CRC is always 0.
// -----------------------------------------------------------------------------
module mtm_alu_frame_rx #(
    parameter int OPERAND_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sin,
    output logic [OPERAND_W-1:0] a_o,
    output logic [OPERAND_W-1:0] b_o,
    output logic [2:0]           op_o,
    output logic                 valid_o,
    output logic                 err_o,
    output logic [2:0]           err_flags_o
);

    localparam int NB = OPERAND_W / 8;
    // The DATA counter saturates at 2*NB+1, so it needs room for that value.
    localparam int CW = $clog2(2 * NB + 2);

    localparam logic [CW-1:0] L_NB  = CW'(NB);
    localparam logic [CW-1:0] L_2NB = CW'(2 * NB);
    localparam logic [CW-1:0] L_MAX = CW'(2 * NB + 1);
    localparam logic [CW-1:0] L_ONE = CW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TYPE    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_STOP    = 2'd3;

    logic [1:0]           r_state;
    logic                 r_type;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_pay;
    logic [CW-1:0]        r_dcnt;
    logic [OPERAND_W-1:0] r_a_sh;
    logic [OPERAND_W-1:0] r_b_sh;

    logic [OPERAND_W+7:0] w_a_cat;
    logic [OPERAND_W+7:0] w_b_cat;
    logic [2:0]           w_ctl_op;
    logic                 w_data_bad;
    logic                 w_crc_bad;
    logic                 w_op_bad;
    logic [2:0]           w_err_flags;
    logic                 w_pkt_end;
    logic                 w_store_byte;

    // Appending the new byte and keeping the low OPERAND_W bits shifts the
    // operand left by one byte; this also works for OPERAND_W == 8.
    assign w_a_cat = {r_a_sh, r_pay};
    assign w_b_cat = {r_b_sh, r_pay};

    assign w_ctl_op   = r_pay[6:4];
    assign w_data_bad = (r_dcnt != L_2NB);
    // Legal codes 000, 001, 100, 101 are exactly those with OP[1] clear.
    assign w_op_bad   = w_ctl_op[1];

    // Priority DATA > CRC > OP, so exactly one flag is ever raised.
    assign w_err_flags = w_data_bad ? 3'b100 :
                         w_crc_bad  ? 3'b010 :
                         w_op_bad   ? 3'b001 : 3'b000;

    // A packet ends on a framing error or on any well-framed CTL stop bit;
    // both produce a pulse and restart the byte count and CRC.
    assign w_pkt_end    = (r_state == S_STOP) && (!sin || r_type);
    assign w_store_byte = (r_state == S_STOP) && sin && !r_type &&
                          (r_dcnt < L_2NB);

`ifdef MTM_ALU_FRAME_RX_CRC_CHECK_EN
    logic [3:0] r_crc;
    logic       w_crc_feed;
    logic       w_crc_bit;
    logic       w_crc_fb;
    logic [3:0] w_crc_step;

    // DATA frames feed all 8 payload bits. In the CTL frame the leading 0 is
    // replaced by the constant 1, then the three OP bits follow; the CRC
    // nibble itself is not fed.
    assign w_crc_feed = !r_type || (r_bit_cnt < 3'd4);
    assign w_crc_bit  = (r_type && (r_bit_cnt == 3'd0)) ? 1'b1 : sin;
    assign w_crc_fb   = r_crc[3] ^ w_crc_bit;
    assign w_crc_step = {r_crc[2], r_crc[1], r_crc[0] ^ w_crc_fb, w_crc_fb};
    assign w_crc_bad  = (r_crc != r_pay[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 4'd0;
        end else if (w_pkt_end) begin
            r_crc <= 4'd0;
        end else if ((r_state == S_PAYLOAD) && w_crc_feed) begin
            r_crc <= w_crc_step;
        end
    end
`else
    assign w_crc_bad = 1'b0;
`endif

    // Frame FSM, packet bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_type      <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_dcnt      <= '0;
            a_o         <= '0;
            b_o         <= '0;
            op_o        <= 3'd0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= 3'd0;
        end else begin
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= 3'd0;
            case (r_state)
                S_IDLE: begin
                    if (!sin) begin
                        r_state <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    r_type    <= sin;
                    r_bit_cnt <= 3'd0;
                    r_state   <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_state <= S_IDLE;
                    if (!sin) begin
                        // Framing error: drop everything gathered so far.
                        err_o       <= 1'b1;
                        err_flags_o <= 3'b100;
                        r_dcnt      <= '0;
                    end else if (!r_type) begin
                        if (r_dcnt != L_MAX) begin
                            r_dcnt <= r_dcnt + L_ONE;
                        end
                    end else begin
                        r_dcnt <= '0;
                        if (w_err_flags != 3'b000) begin
                            err_o       <= 1'b1;
                            err_flags_o <= w_err_flags;
                        end else begin
                            valid_o <= 1'b1;
                            a_o     <= r_a_sh;
                            b_o     <= r_b_sh;
                            op_o    <= w_ctl_op;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Payload shifter and operand assembly; pure data, no reset needed since
    // a complete packet overwrites every operand byte before it is used.
    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD) begin
            r_pay <= {r_pay[6:0], sin};
        end
        if (w_store_byte) begin
            if (r_dcnt < L_NB) begin
                r_a_sh <= w_a_cat[OPERAND_W-1:0];
            end else begin
                r_b_sh <= w_b_cat[OPERAND_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_mtm_alu_frame_rx
//
// Drives directed and randomized frame sequences into mtm_alu_frame_rx. A
// packet-level reference model turns each sent frame into an expected pulse
// (kind, flags, held operands, cycle of arrival) pushed onto a queue; a
// monitor pops and compares whenever the DUT pulses valid_o or err_o.
// -----------------------------------------------------------------------------
module tb_mtm_alu_frame_rx;

    localparam int W  = 32;
    localparam int NB = W / 8;

`ifdef MTM_ALU_FRAME_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b1;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic [2:0]   op_o;
    logic         valid_o;
    logic         err_o;
    logic [2:0]   err_flags_o;

    mtm_alu_frame_rx #(.OPERAND_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .a_o        (a_o),
        .b_o        (b_o),
        .op_o       (op_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .err_flags_o(err_flags_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic         is_err;
        logic [2:0]   flags;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        int           cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference model state: bytes of the packet in progress, last good result.
    logic [7:0] m_bytes[$];
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [2:0]   m_op = 3'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC-4 as polynomial long division of {A,B,1,OP}*x^4 by x^4+x+1.
    function automatic logic [3:0] crc4(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op);
        logic [2*W+7:0] m;
        m = {a, b, 1'b1, op, 4'b0000};
        for (int i = 2*W+7; i >= 4; i--) begin
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        end
        return m[3:0];
    endfunction

    task automatic model_frame(input logic t, input logic [7:0] d, input logic stop_ok);
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        bit           pulse;
        pulse    = 1'b1;
        e.cyc    = cyc;
        e.is_err = 1'b1;
        e.flags  = 3'b000;
        if (!stop_ok) begin
            e.flags = 3'b100;
            m_bytes.delete();
        end else if (!t) begin
            m_bytes.push_back(d);
            pulse = 1'b0;
        end else begin
            op = d[6:4];
            if (m_bytes.size() != 2*NB) begin
                e.flags = 3'b100;
            end else begin
                a = '0;
                b = '0;
                for (int i = 0; i < NB; i++) begin
                    a = (a << 8) | W'(m_bytes[i]);
                    b = (b << 8) | W'(m_bytes[NB+i]);
                end
                if (CRC_EN && (crc4(a, b, op) != d[3:0])) e.flags = 3'b010;
                else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.flags = 3'b001;
                else begin
                    e.is_err = 1'b0;
                    m_a = a;
                    m_b = b;
                    m_op = op;
                end
            end
            m_bytes.delete();
        end
        if (pulse) begin
            e.a  = m_a;
            e.b  = m_b;
            e.op = m_op;
            q.push_back(e);
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic t, input logic [7:0] d, input logic stop_ok);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop_ok);
        model_frame(t, d, stop_ok);
        sin = 1'b1;
    endtask

    task automatic send_packet(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic [3:0] crc, input int gap);
        for (int i = 0; i < NB; i++) begin
            send_frame(1'b0, a[W-1-8*i -: 8], 1'b1);
            idle(gap);
        end
        for (int i = 0; i < NB; i++) begin
            send_frame(1'b0, b[W-1-8*i -: 8], 1'b1);
            idle(gap);
        end
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
        idle(gap);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (valid_o || err_o)) begin
            check("exclusive", 64'(valid_o & err_o), 64'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {valid_o, err_o}, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("err_o", err_o, mon_e.is_err);
                check("valid_o", valid_o, !mon_e.is_err);
                check("latency", 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.is_err) check("err_flags", err_flags_o, mon_e.flags);
                check("a_o", a_o, mon_e.a);
                check("b_o", b_o, mon_e.b);
                check("op_o", op_o, mon_e.op);
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_a"}, a_o, 64'd0);
        check({tag, "_b"}, b_o, 64'd0);
        check({tag, "_op"}, op_o, 64'd0);
        check({tag, "_pulses"}, {valid_o, err_o, err_flags_o}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [3:0]   crc;
        int           r;
        int           n;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        idle(3);

        // All-ones operands, ADD.
        send_packet('1, '1, 3'b100, crc4('1, '1, 3'b100), 0);
        idle(2);

        // CTL 0x40 with a CRC field that does not match A=5, B=2.
        send_packet(W'(5), W'(2), 3'b100, 4'h0, 1);

        // Invalid OP with correct CRC.
        send_packet(W'(10), W'(10), 3'b010, crc4(W'(10), W'(10), 3'b010), 0);

        // Short packet: two DATA frames then CTL 0x50.
        send_frame(1'b0, 8'h00, 1'b1);
        send_frame(1'b0, 8'h0A, 1'b1);
        send_frame(1'b1, 8'h50, 1'b1);

        // Framing error in the 3rd DATA frame, then a good packet back-to-back.
        send_frame(1'b0, 8'h12, 1'b1);
        send_frame(1'b0, 8'h34, 1'b1);
        send_frame(1'b0, 8'h56, 1'b0);
        send_packet(32'hCAFE_0001, 32'h0BAD_F00D, 3'b101,
                    crc4(32'hCAFE_0001, 32'h0BAD_F00D, 3'b101), 0);

        // Too many DATA frames: counter saturates, CTL still flags DATA.
        for (int i = 0; i < 2*NB + 3; i++) send_frame(1'b0, 8'($urandom), 1'b1);
        send_frame(1'b1, 8'h00, 1'b1);
        idle(1);

        // Randomized packets.
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            a  = $urandom;
            b  = $urandom;
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : {1'($urandom), 1'b0, 1'($urandom)};
            crc = crc4(a, b, op);
            if (r == 0) crc = crc ^ 4'($urandom_range(1, 15));
            if (r == 1) begin
                n = $urandom_range(0, 2*NB);
                for (int i = 0; i < n; i++) send_frame(1'b0, 8'($urandom), 1'b1);
                send_frame(1'($urandom), 8'($urandom), 1'b0);
                idle($urandom_range(0, 2));
            end else if (r == 2) begin
                n = $urandom_range(0, 2*NB + 3);
                if (n == 2*NB) n = 2*NB + 1;
                for (int i = 0; i < n; i++) send_frame(1'b0, 8'($urandom), 1'b1);
                send_frame(1'b1, {1'b0, op, crc}, 1'b1);
            end else begin
                send_packet(a, b, op, crc, $urandom_range(0, 2));
            end
        end

        // A known good packet so the outputs are non-zero before reset.
        send_packet(32'h1234_5678, 32'h0000_00FF, 3'b001,
                    crc4(32'h1234_5678, 32'h0000_00FF, 3'b001), 1);
        idle(2);
        check("pre_reset_a", a_o, 64'h1234_5678);

        // Reset in the middle of a packet and a frame.
        send_frame(1'b0, 8'hAA, 1'b1);
        send_frame(1'b0, 8'h55, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        m_bytes.delete();
        m_a = '0;
        m_b = '0;
        m_op = 3'd0;
        sin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        check_cleared("post_reset");

        // Reception restarts cleanly after reset.
        send_packet(32'h0000_1234, 32'h0000_00FF, 3'b001,
                    crc4(32'h0000_1234, 32'h0000_00FF, 3'b001), 0);
        idle(5);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
